dcache_flush_walker: RTL and testbench
======================================

Name: dcache_flush_walker

Overview:
- Read-side controller for the dcache's register arrays (valid, dirty, tag, data).
- On a flush request it walks every set index, reads the arrays combinationally, writes each valid and dirty line back to memory, then clears that set's dirty bit.
- Sits between the dcache control logic and the memory-side arbiter port; holds busy high so the cache stalls CPU requests while it runs.

Parameters:
- s_index, 3, set index width; num_sets = 2**s_index.
- s_offset, 5, byte-offset width; line width s_line = 8*2**s_offset (256 bits).
- s_tag, 32-s_index-s_offset (24), tag width. Fixed by the formula, never overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush_req  in  1  level request, sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- flush_done  out  1  one-cycle pulse when the walk finishes.
- arr_rindex  out  s_index  read index driven to all arrays.
- valid_in  in  1  valid-array dataout at arr_rindex.
- dirty_in  in  1  dirty-array dataout at arr_rindex.
- tag_in  in  s_tag  tag-array dataout.
- data_in  in  s_line  data-array dataout.
- dirty_load  out  1  dirty-array write enable.
- dirty_windex  out  s_index  dirty-array write index.
- dirty_datain  out  1  always 0.
- mem_write  out  1  memory write request.
- mem_address  out  32  {tag, index, s_offset'b0}.
- mem_wdata  out  s_line  captured line.
- mem_resp  in  1  memory write complete.

Behaviour:
- Array reads are combinational, so index and data are valid in the same cycle.
- FSM states: IDLE, SCAN, WRITE, CLEAR, DONE. Reset (rst_n=0 at a clk edge) forces IDLE, idx=0, and all outputs 0: busy, flush_done, dirty_load, mem_write, mem_address, mem_wdata.
- IDLE: if flush_req=1, set idx=0 and go to SCAN.
- SCAN: arr_rindex=idx.
  - If valid_in & dirty_in: capture tag_in, data_in and idx into registers; go to WRITE.
  - Otherwise, if idx is the last set, go to DONE; else idx+1 and stay in SCAN (one cycle per clean set).
- WRITE: mem_write=1, with address and wdata taken from the captured registers and held stable. Stay until mem_resp=1, then go to CLEAR. mem_write drops in the cycle after mem_resp.
- CLEAR: dirty_load=1, dirty_windex=captured idx, dirty_datain=0 for exactly one cycle. Then, if idx is the last set, go to DONE; else idx+1 and go to SCAN.
- DONE: flush_done=1 for one cycle, then go to IDLE. busy is 0 from IDLE onward.
- Latency:
  - All sets clean: 2**s_index + 2 cycles from the flush_req edge to flush_done.
  - Each dirty line adds (memory latency + 2) cycles.
- Boundary conditions:
  - idx wraps at the last set and terminates the walk; it never re-scans set 0.
  - mem_resp outside WRITE is ignored.
  - flush_req outside IDLE is ignored. A flush_req still high in the cycle after DONE starts a new walk.
  - Reset mid-WRITE drops mem_write in the next cycle and issues no clear.
  - The arrays' write-bypass (dataout=datain while loading) is harmless, because CLEAR never samples the inputs.

Optional Feature:
- Macro DCACHE_FLUSH_INVALIDATE_EN.
- Defined:
  - Adds ports valid_load (out, 1), valid_windex (out, s_index) and valid_datain (out, 1, always 0).
  - Every scanned set gets its valid bit cleared. For a clean set the clear happens in the SCAN cycle; for a dirty set it happens together with the dirty clear in CLEAR. After a flush the whole cache is invalid.
- Undefined: these ports are absent and valid bits are untouched.

Decomposition:
- Package dcache_flush_pkg holds:
  - the state enum flush_state_t {IDLE, SCAN, WRITE, CLEAR, DONE};
  - the localparam S_OFFSET_DEFAULT=5;
  - the function make_addr(tag, idx) that returns the 32-bit address.
- No sub-module: the index counter and capture registers are inline.

Test Plan:
- All sets clean, flush_req held 1 cycle → mem_write never asserted; flush_done pulses exactly 10 cycles after the request edge (s_index=3).
- Set 5 valid+dirty, tag 0xABCDEF, mem_resp after 3 cycles → mem_address=0xABCDEF_A0 (tag<<8 | 5<<5); wdata matches the line; dirty_load=1 with windex=5 once; flush_done follows.
- Sets 0 and 7 dirty → two writes in index order (0, then 7); the write for set 7 ends the walk with no wrap back to set 0.
- rst_n=0 while in WRITE at set 2 → mem_write=0 and busy=0 on the next cycle; dirty bit 2 is not cleared; a new flush rewrites set 2.
- flush_req held high continuously → back-to-back walks, with IDLE visible for exactly one cycle between them; stray mem_resp pulses in IDLE are ignored.
- With DCACHE_FLUSH_INVALIDATE_EN defined → valid_load is pulsed for all 8 indices and all valid bits read 0 afterwards.

Source files
------------

// File: rtl/dcache_flush_pkg.sv
// Shared types and helpers for the dcache flush walker.
package dcache_flush_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    CLEAR,
    DONE
  } flush_state_t;

  localparam int unsigned S_OFFSET_DEFAULT = 5;

  // Line-aligned byte address: {tag, index, zero offset}.
  function automatic logic [31:0] make_addr(input logic [31:0]   tag,
                                            input logic [31:0]   idx,
                                            input int unsigned   s_index,
                                            input int unsigned   s_offset);
    make_addr = (tag << (s_index + s_offset)) | (idx << s_offset);
  endfunction

endpackage

// File: rtl/dcache_flush_walker.sv
// Walks every dcache set on a flush request and writes back valid+dirty lines.
// Optional DCACHE_FLUSH_INVALIDATE_EN also clears every valid bit during the walk.
module dcache_flush_walker
  import dcache_flush_pkg::*;
#(
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_offset = S_OFFSET_DEFAULT,
  localparam int unsigned s_tag   = 32 - s_index - s_offset,
  localparam int unsigned s_line  = 8 * (2 ** s_offset)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_req,
  output logic                busy,
  output logic                flush_done,
  output logic [s_index-1:0]  arr_rindex,
  input  logic                valid_in,
  input  logic                dirty_in,
  input  logic [s_tag-1:0]    tag_in,
  input  logic [s_line-1:0]   data_in,
  output logic                dirty_load,
  output logic [s_index-1:0]  dirty_windex,
  output logic                dirty_datain,
`ifdef DCACHE_FLUSH_INVALIDATE_EN
  output logic                valid_load,
  output logic [s_index-1:0]  valid_windex,
  output logic                valid_datain,
`endif
  output logic                mem_write,
  output logic [31:0]         mem_address,
  output logic [s_line-1:0]   mem_wdata,
  input  logic                mem_resp
);

  flush_state_t        state_q, state_d;
  logic [s_index-1:0]  idx_q, idx_d;
  logic [s_tag-1:0]    cap_tag_q, cap_tag_d;
  logic [s_line-1:0]   cap_data_q, cap_data_d;
  logic [s_index-1:0]  cap_idx_q, cap_idx_d;
  logic                last_set;
  logic                inv_load;

  assign last_set = (idx_q == {s_index{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cap_tag_q  <= '0;
      cap_data_q <= '0;
      cap_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_tag_q  <= cap_tag_d;
      cap_data_q <= cap_data_d;
      cap_idx_q  <= cap_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_tag_d  = cap_tag_q;
    cap_data_d = cap_data_q;
    cap_idx_d  = cap_idx_q;
    busy       = (state_q != IDLE);
    flush_done = 1'b0;
    dirty_load = 1'b0;
    mem_write  = 1'b0;
    inv_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (valid_in && dirty_in) begin
          cap_tag_d  = tag_in;
          cap_data_d = data_in;
          cap_idx_d  = idx_q;
          state_d    = WRITE;
        end else begin
          // Clean or invalid set: optional invalidate happens right here.
          inv_load = 1'b1;
          if (last_set) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        if (mem_resp) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        dirty_load = 1'b1;
        inv_load   = 1'b1;
        if (last_set) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign arr_rindex   = idx_q;
  assign dirty_windex = cap_idx_q;
  assign dirty_datain = 1'b0;
  assign mem_address  = make_addr(32'(cap_tag_q), 32'(cap_idx_q), s_index, s_offset);
  assign mem_wdata    = cap_data_q;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  // idx_q still equals cap_idx_q during CLEAR, so one index serves both cases.
  assign valid_load   = inv_load;
  assign valid_windex = idx_q;
  assign valid_datain = 1'b0;
`else
  logic unused_inv_load;
  assign unused_inv_load = inv_load;
`endif

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Directed self-checking bench for dcache_flush_walker (s_index=3, s_offset=5).
module tb_dcache_flush_walker;

  localparam int unsigned MemLat = 3;
  localparam int unsigned Bound  = 200;

  logic         clk;
  logic         rst_n;
  logic         flush_req;
  logic         busy;
  logic         flush_done;
  logic [2:0]   arr_rindex;
  logic         valid_in;
  logic         dirty_in;
  logic [23:0]  tag_in;
  logic [255:0] data_in;
  logic         dirty_load;
  logic [2:0]   dirty_windex;
  logic         dirty_datain;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic         model_resp;
  logic         stray_resp;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
  logic         valid_load;
  logic [2:0]   valid_windex;
  logic         valid_datain;
  logic [7:0]   vmask;
`endif

  // Array and memory models
  logic [7:0]   valid_v;
  logic [7:0]   dirty_v;
  logic [23:0]  tag_a  [8];
  logic [255:0] data_a [8];
  int unsigned  wcnt;
  int unsigned  bad_datain;
  logic [31:0]  wr_addr_q [$];
  logic [255:0] wr_data_q [$];
  logic [2:0]   clr_q     [$];

  int n_checks;
  int n_fail;
  int lat;

  assign valid_in = valid_v[arr_rindex];
  assign dirty_in = dirty_v[arr_rindex];
  assign tag_in   = tag_a[arr_rindex];
  assign data_in  = data_a[arr_rindex];
  assign mem_resp = model_resp | stray_resp;

  dcache_flush_walker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_req    (flush_req),
    .busy         (busy),
    .flush_done   (flush_done),
    .arr_rindex   (arr_rindex),
    .valid_in     (valid_in),
    .dirty_in     (dirty_in),
    .tag_in       (tag_in),
    .data_in      (data_in),
    .dirty_load   (dirty_load),
    .dirty_windex (dirty_windex),
    .dirty_datain (dirty_datain),
`ifdef DCACHE_FLUSH_INVALIDATE_EN
    .valid_load   (valid_load),
    .valid_windex (valid_windex),
    .valid_datain (valid_datain),
`endif
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers once mem_write has been high for MemLat full cycles.
  always @(negedge clk) begin
    if (mem_write) begin
      wcnt       <= wcnt + 1;
      model_resp <= (wcnt + 1 == MemLat + 1);
      if (wcnt == 0) begin
        wr_addr_q.push_back(mem_address);
        wr_data_q.push_back(mem_wdata);
      end
    end else begin
      wcnt       <= 0;
      model_resp <= 1'b0;
    end
    if (dirty_load) begin
      clr_q.push_back(dirty_windex);
      dirty_v[dirty_windex] <= dirty_datain;
      if (dirty_datain) bad_datain <= bad_datain + 1;
    end
`ifdef DCACHE_FLUSH_INVALIDATE_EN
    if (valid_load) begin
      vmask[valid_windex]   <= 1'b1;
      valid_v[valid_windex] <= valid_datain;
      if (valid_datain) bad_datain <= bad_datain + 1;
    end
`endif
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    clr_q.delete();
  endtask

  // Raise flush_req after a posedge; count negedges until flush_done is seen.
  task automatic run_flush(input bit hold, output int n);
    @(posedge clk);
    #1 flush_req = 1'b1;
    n = 0;
    for (int i = 0; i < Bound; i++) begin
      @(negedge clk);
      n++;
      if (!hold && n == 2) flush_req = 1'b0;
      if (flush_done) break;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    flush_req  = 1'b0;
    stray_resp = 1'b0;
    wcnt       <= 0;
    model_resp <= 1'b0;
    bad_datain <= 0;
    valid_v    <= 8'hFF;
    dirty_v    <= 8'h00;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
    vmask      <= 8'h00;
`endif
    for (int i = 0; i < 8; i++) begin
      tag_a[i]  <= 24'h0;
      data_a[i] <= {8{32'hC0DE0000 | i}};
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_dirty_load", dirty_load, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // All clean
    clear_logs();
    run_flush(1'b0, lat);
    check("clean_latency", lat, 10);
    check("clean_writes", wr_addr_q.size(), 0);
    check("clean_clears", clr_q.size(), 0);
    @(negedge clk);
    check("clean_done_pulse", flush_done, 0);
    check("clean_busy_after", busy, 0);

    // Set 5 dirty
    valid_v   <= 8'hFF;
    dirty_v   <= 8'h20;
    tag_a[5]  <= 24'hABCDEF;
    @(negedge clk);
    clear_logs();
    run_flush(1'b0, lat);
    check("s5_latency", lat, 15);
    check("s5_writes", wr_addr_q.size(), 1);
    check("s5_address", wr_addr_q[0], 32'hABCDEFA0);
    check("s5_wdata", wr_data_q[0], {8{32'hC0DE0005}});
    check("s5_clears", clr_q.size(), 1);
    check("s5_clear_idx", clr_q[0], 5);
    @(negedge clk);
    check("s5_dirty_after", dirty_v, 8'h00);

    // Sets 0 and 7 dirty
    valid_v  <= 8'hFF;
    dirty_v  <= 8'h81;
    tag_a[0] <= 24'h111111;
    tag_a[7] <= 24'h222222;
    @(negedge clk);
    clear_logs();
    run_flush(1'b0, lat);
    check("s07_latency", lat, 20);
    check("s07_writes", wr_addr_q.size(), 2);
    check("s07_addr_first", wr_addr_q[0], 32'h11111100);
    check("s07_addr_second", wr_addr_q[1], 32'h222222E0);
    check("s07_wdata_second", wr_data_q[1], {8{32'hC0DE0007}});
    check("s07_clear_order", {clr_q[0], clr_q[1]}, {3'd0, 3'd7});
    repeat (3) @(negedge clk);
    check("s07_no_rewalk", busy, 0);
    check("s07_writes_final", wr_addr_q.size(), 2);
`ifndef DCACHE_FLUSH_INVALIDATE_EN
    check("valid_untouched", valid_v, 8'hFF);
`endif

    // Reset in the middle of WRITE at set 2
    valid_v  <= 8'hFF;
    dirty_v  <= 8'h04;
    tag_a[2] <= 24'h333333;
    @(negedge clk);
    clear_logs();
    @(posedge clk);
    #1 flush_req = 1'b1;
    lat = 0;
    for (int i = 0; i < Bound; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 2) flush_req = 1'b0;
      if (mem_write) break;
    end
    check("rstw_reached_write", mem_write, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw_mem_write", mem_write, 0);
    check("rstw_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_no_clear", clr_q.size(), 0);
    check("rstw_dirty_kept", dirty_v[2], 1);
    clear_logs();
    run_flush(1'b0, lat);
    check("rstw_latency", lat, 15);
    check("rstw_rewrite_addr", wr_addr_q[0], 32'h33333340);
    @(negedge clk);
    check("rstw_dirty_cleared", dirty_v[2], 0);

    // Stray mem_resp in IDLE, then back-to-back walks
    valid_v <= 8'hFF;
    dirty_v <= 8'h00;
    @(negedge clk);
    clear_logs();
    stray_resp = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_write", mem_write, 0);
    stray_resp = 1'b0;
    run_flush(1'b1, lat);
    check("b2b_first_latency", lat, 10);
    @(negedge clk);
    check("b2b_idle_gap", busy, 0);
    @(negedge clk);
    check("b2b_restart", busy, 1);
    flush_req = 1'b0;
    lat = 0;
    for (int i = 0; i < Bound; i++) begin
      @(negedge clk);
      lat++;
      if (flush_done) break;
    end
    check("b2b_second_latency", lat, 8);
    check("b2b_writes", wr_addr_q.size(), 0);

`ifdef DCACHE_FLUSH_INVALIDATE_EN
    valid_v <= 8'hFF;
    dirty_v <= 8'h12;
    vmask   <= 8'h00;
    @(negedge clk);
    clear_logs();
    run_flush(1'b0, lat);
    check("inv_latency", lat, 20);
    check("inv_writes", wr_addr_q.size(), 2);
    @(negedge clk);
    check("inv_mask", vmask, 8'hFF);
    check("inv_valid_after", valid_v, 8'h00);
`endif

    check("datain_zero", bad_datain, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
